ntt_stage_sequencer: RTL and testbench

Frame-level sequencer for the 512-point, 32-lane NTT pipeline. It accepts a frame-start pulse at the pipeline input, tracks the 16-beat input window, and issues registered per-stage start pulses to every butterfly/permutation stage. It also generates the pipeline output-start and last-beat markers and keeps an in-flight frame count. It sits beside the datapath and drives the `in_start` port of each stage.

---
 rtl/ntt_seq_pkg.sv | 18 +
 rtl/ntt_pulse_delay.sv | 24 ++
 rtl/ntt_stage_sequencer.sv | 138 +++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_seq_pkg.sv
// Shared constants and types for the NTT frame sequencer.
// Frame geometry defaults to 512 points over 32 lanes.
package ntt_seq_pkg;

    localparam int NUM_POINTS_DEF      = 512;
    localparam int INPUT_PER_CYCLE_DEF = 32;
    localparam int BEATS               = NUM_POINTS_DEF / INPUT_PER_CYCLE_DEF;
    localparam int BEAT_W              = $clog2(BEATS);
    localparam int NUM_STAGES_DEF      = 9;
    localparam int STAGE_LAT_DEF       = 5;
    localparam int INFLIGHT_MAX        = 15;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } seq_state_t;

endpackage

// File: rtl/ntt_pulse_delay.sv
// Synchronous-reset 1-bit pulse delay line of DEPTH cycles.
// Every in-flight pulse occupies its own bit, so overlapping pulses never merge.
module ntt_pulse_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(d);
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Frame sequencer for the NTT pipeline: input window FSM, stage start taps, output markers.
// Build macro NTT_SEQ_ERR_EN: drop in_start during LOAD and flag sticky err; otherwise restart.
module ntt_stage_sequencer
    import ntt_seq_pkg::*;
#(
    parameter int NUM_POINTS      = NUM_POINTS_DEF,
    parameter int INPUT_PER_CYCLE = INPUT_PER_CYCLE_DEF,
    parameter int NUM_STAGES      = NUM_STAGES_DEF,
    parameter int STAGE_LAT       = STAGE_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    output logic                  in_busy,
    output logic [BEAT_W-1:0]     in_beat,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  out_start,
    output logic                  out_last,
    output logic [3:0]            inflight,
    output logic                  idle,
    output logic                  err
);

    localparam int FRAME_BEATS = NUM_POINTS / INPUT_PER_CYCLE;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);
    localparam int OUT_DLY = 1 + NUM_STAGES * STAGE_LAT;

    seq_state_t state, state_n;
    logic [BEAT_W-1:0] beat_n;
    logic [3:0] inflight_n;
    logic accept;
    logic start_in_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_beat  <= '0;
            inflight <= '0;
        end else begin
            state    <= state_n;
            in_beat  <= beat_n;
            inflight <= inflight_n;
        end
    end

    always_comb begin
        state_n       = state;
        beat_n        = in_beat;
        accept        = 1'b0;
        start_in_load = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_start) begin
                    accept  = 1'b1;
                    beat_n  = BEAT_W'(1);
                    state_n = LOAD;
                end
            end
            LOAD: begin
                start_in_load = in_start;
`ifdef NTT_SEQ_ERR_EN
                if (in_beat == LAST_BEAT) begin
                    beat_n  = '0;
                    state_n = IDLE;
                end else begin
                    beat_n = in_beat + BEAT_W'(1);
                end
`else
                // A second start reopens the window; the earlier frame keeps its pulses
                if (in_start) begin
                    accept = 1'b1;
                    beat_n = BEAT_W'(1);
                end else if (in_beat == LAST_BEAT) begin
                    beat_n  = '0;
                    state_n = IDLE;
                end else begin
                    beat_n = in_beat + BEAT_W'(1);
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        inflight_n = inflight;
        unique case ({accept, out_last})
            2'b10: if (inflight != 4'(INFLIGHT_MAX)) inflight_n = inflight + 4'd1;
            2'b01: inflight_n = inflight - 4'd1;
            default: inflight_n = inflight;
        endcase
    end

`ifdef NTT_SEQ_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (start_in_load) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_start;
    assign unused_start = start_in_load;
    assign err = 1'b0;
`endif

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_tap
        ntt_pulse_delay #(.DEPTH(1 + k * STAGE_LAT)) u_tap (
            .clk (clk),
            .rst (rst),
            .d   (accept),
            .q   (stage_start[k])
        );
    end

    ntt_pulse_delay #(.DEPTH(OUT_DLY)) u_out_start (
        .clk (clk),
        .rst (rst),
        .d   (accept),
        .q   (out_start)
    );

    ntt_pulse_delay #(.DEPTH(FRAME_BEATS - 1)) u_out_last (
        .clk (clk),
        .rst (rst),
        .d   (out_start),
        .q   (out_last)
    );

    assign in_busy = (state == LOAD);
    assign idle    = (inflight == 4'd0) && !in_busy;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed self-checking bench for ntt_stage_sequencer (default and 1-stage builds).
// Expectations follow NTT_SEQ_ERR_EN when the macro is defined.
module tb_ntt_stage_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_start = 1'b0;
    logic in_start_s = 1'b0;

    logic       in_busy, idle, err, out_start, out_last;
    logic [3:0] in_beat, inflight;
    logic [8:0] stage_start;

    logic       s_busy, s_idle, s_err, s_os, s_ol;
    logic [3:0] s_beat, s_inflight;
    logic [0:0] s_stage;

    int cyc;
    int n_cmp;
    int n_err;
    int pk;
    int q_s0[$], q_s8[$], q_os[$], q_ol[$];
    int qs_s0[$], qs_os[$], qs_ol[$];

    always #5 clk = ~clk;

    ntt_stage_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_start    (in_start),
        .in_busy     (in_busy),
        .in_beat     (in_beat),
        .stage_start (stage_start),
        .out_start   (out_start),
        .out_last    (out_last),
        .inflight    (inflight),
        .idle        (idle),
        .err         (err)
    );

    ntt_stage_sequencer #(.NUM_STAGES(1), .STAGE_LAT(1)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .in_start    (in_start_s),
        .in_busy     (s_busy),
        .in_beat     (s_beat),
        .stage_start (s_stage),
        .out_start   (s_os),
        .out_last    (s_ol),
        .inflight    (s_inflight),
        .idle        (s_idle),
        .err         (s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (stage_start[0]) q_s0.push_back(cyc);
        if (stage_start[8]) q_s8.push_back(cyc);
        if (out_start) q_os.push_back(cyc);
        if (out_last) q_ol.push_back(cyc);
        if (s_stage[0]) qs_s0.push_back(cyc);
        if (s_os) qs_os.push_back(cyc);
        if (s_ol) qs_ol.push_back(cyc);
        if (int'(inflight) > pk) pk = int'(inflight);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic clear_log();
        q_s0.delete(); q_s8.delete(); q_os.delete(); q_ol.delete();
        qs_s0.delete(); qs_os.delete(); qs_ol.delete();
        pk = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        clear_log();
    endtask

    task automatic pulse_at(input int n);
        run_to(n);
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        pk = 0;

        // single frame, plus the 1-stage build in parallel
        do_reset();
        chk("rst_busy", in_busy, 0);
        chk("rst_beat", in_beat, 0);
        chk("rst_stage", stage_start, 0);
        chk("rst_out", {out_start, out_last}, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err", err, 0);
        chk("rst_idle", idle, 1);
        run_to(5);
        in_start_s = 1'b1;
        tick();
        in_start_s = 1'b0;
        pulse_at(10);
        chk("a_beat11", in_beat, 1);
        chk("a_inflight11", inflight, 1);
        chk("a_idle11", idle, 0);
        run_to(25);
        chk("a_beat25", in_beat, 15);
        chk("a_busy25", in_busy, 1);
        tick();
        chk("a_busy26", in_busy, 0);
        chk("a_beat26", in_beat, 0);
        run_to(71);
        chk("a_inflight71", inflight, 1);
        tick();
        chk("a_inflight72", inflight, 0);
        run_to(80);
        chk("a_idle80", idle, 1);
        chk("a_s0_n", q_s0.size(), 1);
        chk("a_s0", q_at(q_s0, 0), 11);
        chk("a_s8", q_at(q_s8, 0), 51);
        chk("a_os_n", q_os.size(), 1);
        chk("a_os", q_at(q_os, 0), 56);
        chk("a_ol", q_at(q_ol, 0), 71);
        chk("s_s0", q_at(qs_s0, 0), 6);
        chk("s_os", q_at(qs_os, 0), 7);
        chk("s_ol", q_at(qs_ol, 0), 22);

        // back-to-back frames
        do_reset();
        pulse_at(10);
        pulse_at(26);
        chk("b_beat27", in_beat, 1);
        chk("b_inflight27", inflight, 2);
        run_to(95);
        chk("b_os_n", q_os.size(), 2);
        chk("b_os0", q_at(q_os, 0), 56);
        chk("b_os1", q_at(q_os, 1), 72);
        chk("b_ol0", q_at(q_ol, 0), 71);
        chk("b_ol1", q_at(q_ol, 1), 87);
        chk("b_peak", pk, 2);
        chk("b_idle", idle, 1);

        // start during LOAD
        do_reset();
        pulse_at(10);
        pulse_at(15);
`ifdef NTT_SEQ_ERR_EN
        chk("c_err16", err, 1);
        chk("c_beat16", in_beat, 6);
        chk("c_inflight16", inflight, 1);
        run_to(90);
        chk("c_os_n", q_os.size(), 1);
        chk("c_os0", q_at(q_os, 0), 56);
        chk("c_err90", err, 1);
`else
        chk("c_err16", err, 0);
        chk("c_beat16", in_beat, 1);
        chk("c_inflight16", inflight, 2);
        run_to(90);
        chk("c_os_n", q_os.size(), 2);
        chk("c_os0", q_at(q_os, 0), 56);
        chk("c_os1", q_at(q_os, 1), 61);
        chk("c_ol1", q_at(q_ol, 1), 76);
`endif
        chk("c_idle90", idle, 1);

        // reset mid-flight
        do_reset();
        pulse_at(10);
        run_to(30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_log();
        chk("d_inflight31", inflight, 0);
        chk("d_busy31", in_busy, 0);
        chk("d_beat31", in_beat, 0);
        chk("d_idle31", idle, 1);
        chk("d_err31", err, 0);
        run_to(90);
        chk("d_s8_n", q_s8.size(), 0);
        chk("d_os_n", q_os.size(), 0);
        chk("d_ol_n", q_ol.size(), 0);

        // out_last of one frame coincides with a new accept
        do_reset();
        pulse_at(10);
        pulse_at(55);
        run_to(71);
        chk("e_inflight71", inflight, 2);
        chk("e_ol71", out_last, 1);
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        chk("e_inflight72", inflight, 2);
        chk("e_beat72", in_beat, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
